jaxis_video_tpg: RTL and testbench

// - AXI-Stream video test-pattern generator; sits directly upstream of the AXI-Stream JPEG encoder's video slave.
// - Emits frames of x_size_m1+1 by y_size_m1+1 pixels of {B,G,R} data, with SOF on tuser and EOL on tlast.
// - Supports optional inter-line gaps and single or continuous frames.
// - Gives bring-up and regression a deterministic image source without a sensor.

---
 rtl/jaxis_video_tpg.sv | 202 ++++++++++++++++++++
 tb/tb_jaxis_video_tpg.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jaxis_video_tpg.sv
// AXI-Stream video test-pattern generator: emits {B,G,R} frames with SOF on tuser and EOL on
// tlast, optional inter-line blanking, single-shot or continuous frames.
module jaxis_video_tpg #(
    parameter int unsigned SENSOR_X_SIZE = 720,
    parameter int unsigned SENSOR_Y_SIZE = 720,
    localparam int unsigned XW = $clog2(SENSOR_X_SIZE),
    localparam int unsigned YW = $clog2(SENSOR_Y_SIZE)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [23:0]   m_axis_video_tdata,
    output logic          m_axis_video_tvalid,
    input  logic          m_axis_video_tready,
    output logic          m_axis_video_tuser,
    output logic          m_axis_video_tlast,
    input  logic [XW-1:0] x_size_m1,
    input  logic [YW-1:0] y_size_m1,
    input  logic [1:0]    pattern,
    input  logic [7:0]    hblank_len,
    input  logic          start,
    input  logic          continuous,
    output logic          busy,
    output logic          frame_done,
    output logic [15:0]   frame_count
);

    typedef enum logic [1:0] {StIdle, StActive, StHblank} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    bar_q, bar_d;
    logic [XW-1:0] bar_cnt_q, bar_cnt_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [XW-1:0] xs_q, xs_d;
    logic [YW-1:0] ys_q, ys_d;
    logic [1:0]    pat_q, pat_d;
    logic [7:0]    hb_q, hb_d;
    logic [XW-1:0] bar_w_m1_q, bar_w_m1_d;
    logic          frame_done_q, frame_done_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic          beat;
    logic [XW:0]   x_len;
    logic [XW:0]   bar_w;
    logic [7:0]    r, g, b;
    logic [7:0]    x_lo, y_lo;

    assign m_axis_video_tvalid = (state_q == StActive);
    assign m_axis_video_tuser  = m_axis_video_tvalid && (x_q == '0) && (y_q == '0);
    assign m_axis_video_tlast  = m_axis_video_tvalid && (x_q == xs_q);
    assign m_axis_video_tdata  = {b, g, r};
    assign busy                = (state_q != StIdle);
    assign frame_done          = frame_done_q;
    assign frame_count         = frame_count_q;

    assign beat  = m_axis_video_tvalid && m_axis_video_tready;
    // Bar width is one eighth of the line, never less than one pixel.
    assign x_len = {1'b0, x_size_m1} + 1'b1;
    assign bar_w = x_len >> 3;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        bar_d         = bar_q;
        bar_cnt_d     = bar_cnt_q;
        cnt_d         = cnt_q;
        xs_d          = xs_q;
        ys_d          = ys_q;
        pat_d         = pat_q;
        hb_d          = hb_q;
        bar_w_m1_d    = bar_w_m1_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;

        unique case (state_q)
            StIdle: begin
                if (start || continuous) begin
                    xs_d       = x_size_m1;
                    ys_d       = y_size_m1;
                    pat_d      = pattern;
                    hb_d       = hblank_len;
                    bar_w_m1_d = (bar_w == '0) ? '0 : XW'(bar_w - 1'b1);
                    x_d        = '0;
                    y_d        = '0;
                    bar_d      = '0;
                    bar_cnt_d  = '0;
                    state_d    = StActive;
                end
            end
            StActive: begin
                if (beat) begin
                    if (x_q == xs_q) begin
                        x_d       = '0;
                        bar_d     = '0;
                        bar_cnt_d = '0;
                        if (y_q == ys_q) begin
                            frame_done_d  = 1'b1;
                            frame_count_d = frame_count_q + 16'd1;
                            state_d       = StIdle;
                        end else begin
                            y_d = y_q + 1'b1;
                            if (hb_q != 8'd0) begin
                                cnt_d   = hb_q - 8'd1;
                                state_d = StHblank;
                            end
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        if (bar_cnt_q == bar_w_m1_q) begin
                            bar_cnt_d = '0;
                            if (bar_q != 3'd7) begin
                                bar_d = bar_q + 3'd1;
                            end
                        end else begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end
                    end
                end
            end
            StHblank: begin
                if (cnt_q == 8'd0) begin
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign x_lo = x_q[7:0];
    assign y_lo = y_q[7:0];

    // Pixel decode uses only registered position and latched config, so it holds during stalls.
    always_comb begin
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        unique case (pat_q)
            2'd0: begin
                r = 8'h80;
                g = 8'h40;
                b = 8'hC0;
            end
            2'd1: begin
                r = x_lo;
                g = y_lo;
                b = x_lo + y_lo;
            end
            2'd2: begin
                // white, yellow, cyan, green, magenta, red, blue, black
                r = (bar_q == 3'd0 || bar_q == 3'd1 || bar_q == 3'd4 || bar_q == 3'd5) ?
                    8'hFF : 8'h00;
                g = (bar_q[2] == 1'b0) ? 8'hFF : 8'h00;
                b = (bar_q[0] == 1'b0) ? 8'hFF : 8'h00;
            end
            2'd3: begin
                r = (x_lo[3] ^ y_lo[3]) ? 8'hFF : 8'h00;
                g = r;
                b = r;
            end
            default: begin
                r = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            bar_q         <= '0;
            bar_cnt_q     <= '0;
            cnt_q         <= '0;
            xs_q          <= '0;
            ys_q          <= '0;
            pat_q         <= '0;
            hb_q          <= '0;
            bar_w_m1_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            bar_q         <= bar_d;
            bar_cnt_q     <= bar_cnt_d;
            cnt_q         <= cnt_d;
            xs_q          <= xs_d;
            ys_q          <= ys_d;
            pat_q         <= pat_d;
            hb_q          <= hb_d;
            bar_w_m1_q    <= bar_w_m1_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_jaxis_video_tpg.sv
// Self-checking bench for jaxis_video_tpg: randomized backpressure and config against a
// pixel-level reference model of the test patterns.
module tb_jaxis_video_tpg;

    logic        clk = 1'b0;
    logic        resetn;
    logic [23:0] m_axis_video_tdata;
    logic        m_axis_video_tvalid;
    logic        m_axis_video_tready;
    logic        m_axis_video_tuser;
    logic        m_axis_video_tlast;
    logic [9:0]  x_size_m1;
    logic [9:0]  y_size_m1;
    logic [1:0]  pattern;
    logic [7:0]  hblank_len;
    logic        start;
    logic        continuous;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int fc_model = 0;

    always #5 clk = ~clk;

    jaxis_video_tpg dut (
        .clk                 (clk),
        .resetn              (resetn),
        .m_axis_video_tdata  (m_axis_video_tdata),
        .m_axis_video_tvalid (m_axis_video_tvalid),
        .m_axis_video_tready (m_axis_video_tready),
        .m_axis_video_tuser  (m_axis_video_tuser),
        .m_axis_video_tlast  (m_axis_video_tlast),
        .x_size_m1           (x_size_m1),
        .y_size_m1           (y_size_m1),
        .pattern             (pattern),
        .hblank_len          (hblank_len),
        .start               (start),
        .continuous          (continuous),
        .busy                (busy),
        .frame_done          (frame_done),
        .frame_count         (frame_count)
    );

    // Reference pixel {B,G,R} straight from the pattern definitions.
    function automatic logic [23:0] exp_pix(input int pat, input int x, input int y, input int xs);
        logic [7:0] r, g, b;
        int bw, bar;
        r = 0; g = 0; b = 0;
        case (pat)
            0: begin r = 8'h80; g = 8'h40; b = 8'hC0; end
            1: begin r = 8'(x); g = 8'(y); b = 8'(x + y); end
            2: begin
                bw = (xs + 1) / 8;
                if (bw < 1) bw = 1;
                bar = x / bw;
                if (bar > 7) bar = 7;
                r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 8'hFF : 8'h00;
                g = (bar <= 3) ? 8'hFF : 8'h00;
                b = (bar % 2 == 0) ? 8'hFF : 8'h00;
            end
            default: begin
                r = (((x / 8) ^ (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
                g = r; b = r;
            end
        endcase
        return {b, g, r};
    endfunction

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_axis_video_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset tvalid: got %b expected 0", m_axis_video_tvalid);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset busy: got %b expected 0", busy);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset frame_done: got %b expected 0", frame_done);
        end
        n_checks++;
        if (frame_count !== 16'd0) begin
            n_fail++; $display("FAIL reset frame_count: got %0d expected 0", frame_count);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_axis_video_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got tvalid=%b busy=%b expected 0/0",
                     m_axis_video_tvalid, busy);
        end
    endtask

    // One frame with random backpressure, random start pulses while busy and config scrambled
    // right after the frame starts. Called and returns on a negedge.
    task automatic run_frame(input int pat, input int xs, input int ys, input int hb,
                             input int rdy_pct, input string nm);
        int bx = 0, by = 0, gap = 0, cycles = 0;
        bit in_gap = 0, done = 0, stalled = 0;
        logic [23:0] pd, ed;
        logic pu, pl;
        pd = '0; pu = 0; pl = 0;
        pattern = 2'(pat); x_size_m1 = 10'(xs); y_size_m1 = 10'(ys); hblank_len = 8'(hb);
        m_axis_video_tready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pattern = 2'($urandom); x_size_m1 = 10'($urandom_range(0, 700));
        y_size_m1 = 10'($urandom_range(0, 700)); hblank_len = 8'($urandom);
        n_checks++;
        if (m_axis_video_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL %s latency: got tvalid=%b expected 1", nm, m_axis_video_tvalid);
        end
        while (!done && cycles < 20000) begin
            m_axis_video_tready = ($urandom_range(0, 99) < rdy_pct);
            start = ($urandom_range(0, 3) == 0);
            if (stalled) begin
                n_checks++;
                if ({m_axis_video_tvalid, m_axis_video_tdata, m_axis_video_tuser,
                     m_axis_video_tlast} !== {1'b1, pd, pu, pl}) begin
                    n_fail++;
                    $display("FAIL %s stall_stable: got v=%b d=%h u=%b l=%b expected v=1 d=%h u=%b l=%b",
                             nm, m_axis_video_tvalid, m_axis_video_tdata, m_axis_video_tuser,
                             m_axis_video_tlast, pd, pu, pl);
                end
            end
            if (m_axis_video_tvalid) begin
                if (in_gap) begin
                    n_checks++;
                    if (gap != hb) begin
                        n_fail++; $display("FAIL %s hblank_gap: got %0d expected %0d", nm, gap, hb);
                    end
                    in_gap = 0;
                end
                if (m_axis_video_tready) begin
                    ed = exp_pix(pat, bx, by, xs);
                    n_checks++;
                    if (m_axis_video_tdata !== ed) begin
                        n_fail++;
                        $display("FAIL %s tdata(%0d,%0d): got %h expected %h", nm, bx, by,
                                 m_axis_video_tdata, ed);
                    end
                    n_checks++;
                    if (m_axis_video_tuser !== (bx == 0 && by == 0)) begin
                        n_fail++;
                        $display("FAIL %s tuser(%0d,%0d): got %b expected %b", nm, bx, by,
                                 m_axis_video_tuser, (bx == 0 && by == 0));
                    end
                    n_checks++;
                    if (m_axis_video_tlast !== (bx == xs)) begin
                        n_fail++;
                        $display("FAIL %s tlast(%0d,%0d): got %b expected %b", nm, bx, by,
                                 m_axis_video_tlast, (bx == xs));
                    end
                    if (bx == xs) begin
                        bx = 0;
                        if (by == ys) done = 1;
                        else begin by++; in_gap = 1; gap = 0; end
                    end else begin
                        bx++;
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = m_axis_video_tdata; pu = m_axis_video_tuser; pl = m_axis_video_tlast;
                end
            end else begin
                if (stalled) begin
                    n_checks++; n_fail++;
                    $display("FAIL %s tvalid_dropped: got 0 expected 1", nm);
                end
                if (in_gap) gap++;
                stalled = 0;
            end
            if (done) start = 1'b0;
            cycles++;
            if (!done) @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: got %0d beats in line %0d expected frame end", nm, bx, by);
        end
        @(negedge clk);
        fc_model = (fc_model + 1) % 65536;
        n_checks++;
        if (frame_done !== 1'b1 || m_axis_video_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s frame_done: got done=%b tvalid=%b expected 1/0", nm, frame_done,
                     m_axis_video_tvalid);
        end
        n_checks++;
        if (frame_count !== 16'(fc_model)) begin
            n_fail++; $display("FAIL %s frame_count: got %0d expected %0d", nm, frame_count, fc_model);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0 || m_axis_video_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_frame_idle: got done=%b tvalid=%b busy=%b expected 0/0/0", nm,
                     frame_done, m_axis_video_tvalid, busy);
        end
    endtask

    task automatic test_ramp;
        run_frame(1, 3, 1, 0, 100, "ramp");
        run_frame(1, 3, 1, 0, 50, "ramp_stall");
        run_frame(1, 300, 0, 0, 100, "ramp_wide");
    endtask

    task automatic test_hblank;
        run_frame(1, 1, 2, 3, 100, "hblank3");
        run_frame(3, 9, 3, $urandom_range(1, 6), 60, "hblank_rand");
    endtask

    task automatic test_bars;
        run_frame(2, 15, 0, 0, 100, "bars16");
        run_frame(2, 300, 1, 1, 90, "bars_wide");
        run_frame(2, $urandom_range(0, 40), 1, 0, 70, "bars_rand");
    endtask

    task automatic test_random_patterns;
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(0, 6),
                      $urandom_range(0, 4), $urandom_range(60, 100), "random");
        end
    endtask

    task automatic test_boundary;
        run_frame(1, 0, 0, 0, 100, "single_beat");
        run_frame(3, 0, 3, 2, 50, "one_column");
    endtask

    task automatic test_continuous;
        int pat;
        pat = $urandom_range(0, 3);
        pattern = 2'(pat); x_size_m1 = 10'd1; y_size_m1 = 10'd1; hblank_len = 8'd0;
        m_axis_video_tready = 1'b1;
        continuous = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 4; b++) begin
                n_checks++;
                if (m_axis_video_tvalid !== 1'b1 ||
                    m_axis_video_tdata !== exp_pix(pat, b % 2, b / 2, 1) ||
                    m_axis_video_tuser !== (b == 0) || m_axis_video_tlast !== (b % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL cont beat f%0d b%0d: got v=%b d=%h u=%b l=%b expected v=1 d=%h u=%b l=%b",
                             f, b, m_axis_video_tvalid, m_axis_video_tdata, m_axis_video_tuser,
                             m_axis_video_tlast, exp_pix(pat, b % 2, b / 2, 1), (b == 0),
                             (b % 2 == 1));
                end
                if (f == 2 && b == 1) continuous = 1'b0;
                @(negedge clk);
            end
            fc_model = (fc_model + 1) % 65536;
            n_checks++;
            if (m_axis_video_tvalid !== 1'b0 || frame_done !== 1'b1 ||
                frame_count !== 16'(fc_model)) begin
                n_fail++;
                $display("FAIL cont gap f%0d: got v=%b done=%b count=%0d expected 0/1/%0d", f,
                         m_axis_video_tvalid, frame_done, frame_count, fc_model);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (m_axis_video_tvalid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cont_stop: got tvalid=%b busy=%b expected 0/0", m_axis_video_tvalid,
                         busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame;
        pattern = 2'd1; x_size_m1 = 10'd3; y_size_m1 = 10'd1; hblank_len = 8'd0;
        m_axis_video_tready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_axis_video_tvalid !== 1'b1 || m_axis_video_tdata !== exp_pix(1, 2, 0, 3)) begin
            n_fail++;
            $display("FAIL pre_reset beat2: got v=%b d=%h expected 1/%h", m_axis_video_tvalid,
                     m_axis_video_tdata, exp_pix(1, 2, 0, 3));
        end
        #1 resetn = 1'b0;
        #1;
        fc_model = 0;
        n_checks++;
        if (m_axis_video_tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0 ||
            m_axis_video_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b busy=%b count=%0d last=%b expected 0/0/0/0",
                     m_axis_video_tvalid, busy, frame_count, m_axis_video_tlast);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_frame(1, 3, 1, 0, 100, "after_reset");
    endtask

    initial begin
        resetn = 1'b0;
        m_axis_video_tready = 1'b0;
        x_size_m1 = '0; y_size_m1 = '0; pattern = '0; hblank_len = '0;
        start = 1'b0; continuous = 1'b0;
        test_reset();
        test_ramp();
        test_hblank();
        test_bars();
        test_random_patterns();
        test_boundary();
        test_continuous();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
